// File: rtl/bs_arb_pkg.sv
// Shared arbiter types, default widths and the rotate-priority pick function.
package bs_arb_pkg;

  localparam int unsigned BS_NREQ_DEF  = 3;
  localparam int unsigned BS_WAYW_DEF  = 3;
  localparam int unsigned BS_SETW_DEF  = 10;
  localparam int unsigned BS_BEATW_DEF = 2;
  localparam int unsigned BS_DATAW_DEF = 128;

  typedef struct packed {
    logic                    noop;
    logic [BS_WAYW_DEF-1:0]  way;
    logic [BS_SETW_DEF-1:0]  set;
    logic [BS_BEATW_DEF-1:0] beat;
    logic [BS_BEATW_DEF-1:0] mask;
  } bs_beat_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of valid[n-1:0] scanning upward from rr with wrap (n <= 8).
  function automatic int unsigned rr_pick(input logic [7:0] valid,
                                          input int unsigned rr,
                                          input int unsigned n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    idx   = 0;
    pick  = rr;
    found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < n && !found) begin
        idx = rr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[2:0]]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bs_wr_arbiter_if.sv
// Requester-side and store-side handshake bundle of the BankedStore write arbiter.
interface bs_wr_arbiter_if
  import bs_arb_pkg::*;
#(
  parameter int unsigned NREQ  = BS_NREQ_DEF,
  parameter int unsigned WAYW  = BS_WAYW_DEF,
  parameter int unsigned SETW  = BS_SETW_DEF,
  parameter int unsigned BEATW = BS_BEATW_DEF,
  parameter int unsigned DATAW = BS_DATAW_DEF
);
  localparam int unsigned SRCW = src_w(NREQ);

  logic [NREQ-1:0]       in_valid;
  logic [NREQ-1:0]       in_ready;
  logic [NREQ-1:0]       in_noop;
  logic [NREQ*WAYW-1:0]  in_way;
  logic [NREQ*SETW-1:0]  in_set;
  logic [NREQ*BEATW-1:0] in_beat;
  logic [NREQ*BEATW-1:0] in_mask;
  logic [NREQ-1:0]       in_last;
  logic [NREQ*DATAW-1:0] in_data;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_noop;
  logic [WAYW-1:0]       out_way;
  logic [SETW-1:0]       out_set;
  logic [BEATW-1:0]      out_beat;
  logic [BEATW-1:0]      out_mask;
  logic [SRCW-1:0]       out_src;
  logic [DATAW-1:0]      out_dat_data;
  logic                  busy;

  modport master (
    output in_valid, in_noop, in_way, in_set, in_beat, in_mask, in_last, in_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_noop, out_way, out_set, out_beat, out_mask, out_src,
    input  out_dat_data, busy
  );

  modport slave (
    input  in_valid, in_noop, in_way, in_set, in_beat, in_mask, in_last, in_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_noop, out_way, out_set, out_beat, out_mask, out_src,
    output out_dat_data, busy
  );

endinterface

// File: rtl/bs_arb_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or above ptr_i, wrapping.
module bs_arb_rr_pick
  import bs_arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = src_w(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] grant_o
);

  always_comb begin
    found_o = |valid_i;
    grant_o = IW'(rr_pick(8'(valid_i), 32'(ptr_i), N));
  end

endmodule

// File: rtl/bs_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the BankedStore write port with a one-cycle data delay.
// Optional per-requester beat counters are enabled by defining BS_WR_ARB_PERF_EN.
module bs_wr_arbiter
  import bs_arb_pkg::*;
#(
  parameter int unsigned NREQ  = BS_NREQ_DEF,
  parameter int unsigned WAYW  = BS_WAYW_DEF,
  parameter int unsigned SETW  = BS_SETW_DEF,
  parameter int unsigned BEATW = BS_BEATW_DEF,
  parameter int unsigned DATAW = BS_DATAW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef BS_WR_ARB_PERF_EN
  output logic [NREQ*32-1:0]   perf_beats,
`endif
  bs_wr_arbiter_if.slave       bus
);

  localparam int unsigned     SRCW     = src_w(NREQ);
  localparam logic [SRCW-1:0] LAST_IDX = SRCW'(NREQ - 1);

  arb_state_e       state_q, state_d;
  logic [SRCW-1:0]  rr_q, rr_d;
  logic [SRCW-1:0]  lock_q, lock_d;
  logic             valid_q, valid_d;
  logic             noop_q, noop_d;
  logic [WAYW-1:0]  way_q, way_d;
  logic [SETW-1:0]  set_q, set_d;
  logic [BEATW-1:0] beat_q, beat_d;
  logic [BEATW-1:0] mask_q, mask_d;
  logic [SRCW-1:0]  src_q, src_d;
  logic [DATAW-1:0] slot_data_q, slot_data_d;
  logic [DATAW-1:0] dat_q, dat_d;
  logic             busy_q, busy_d;

  logic             pick_found;
  logic [SRCW-1:0]  pick_idx;
  logic [SRCW-1:0]  sel;
  logic             sel_valid;
  logic             can_accept;
  logic             accept;
  logic             fire;
  logic             sel_noop;
  logic [WAYW-1:0]  sel_way;
  logic [SETW-1:0]  sel_set;
  logic [BEATW-1:0] sel_beat;
  logic [BEATW-1:0] sel_mask;
  logic             sel_last;
  logic [DATAW-1:0] sel_data;
  logic [NREQ-1:0]  ready_vec;

  bs_arb_rr_pick #(.N(NREQ), .IW(SRCW)) u_pick (
    .valid_i (bus.in_valid),
    .ptr_i   (rr_q),
    .found_o (pick_found),
    .grant_o (pick_idx)
  );

  // While locked only the owner is eligible; in_ready follows out_ready combinationally.
  always_comb begin
    sel        = (state_q == LOCKED) ? lock_q : pick_idx;
    sel_valid  = (state_q == LOCKED) ? bus.in_valid[lock_q] : pick_found;
    can_accept = !valid_q || bus.out_ready;
    accept     = can_accept && sel_valid;
    fire       = valid_q && bus.out_ready;
  end

  always_comb begin
    sel_noop  = 1'b0;
    sel_way   = '0;
    sel_set   = '0;
    sel_beat  = '0;
    sel_mask  = '0;
    sel_last  = 1'b0;
    sel_data  = '0;
    ready_vec = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == SRCW'(i)) begin
        sel_noop     = bus.in_noop[i];
        sel_way      = bus.in_way[i*WAYW +: WAYW];
        sel_set      = bus.in_set[i*SETW +: SETW];
        sel_beat     = bus.in_beat[i*BEATW +: BEATW];
        sel_mask     = bus.in_mask[i*BEATW +: BEATW];
        sel_last     = bus.in_last[i];
        sel_data     = bus.in_data[i*DATAW +: DATAW];
        ready_vec[i] = can_accept && ((state_q == LOCKED) || pick_found);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    lock_d      = lock_q;
    valid_d     = valid_q;
    noop_d      = noop_q;
    way_d       = way_q;
    set_d       = set_q;
    beat_d      = beat_q;
    mask_d      = mask_q;
    src_d       = src_q;
    slot_data_d = slot_data_q;
    dat_d       = fire ? slot_data_q : dat_q;
    if (accept) begin
      valid_d     = 1'b1;
      noop_d      = sel_noop;
      way_d       = sel_way;
      set_d       = sel_set;
      beat_d      = sel_beat;
      mask_d      = sel_mask;
      src_d       = sel;
      slot_data_d = sel_data;
      if (sel_last) begin
        state_d = IDLE;
        rr_d    = (sel == LAST_IDX) ? '0 : sel + 1'b1;
      end else begin
        state_d = LOCKED;
        lock_d  = sel;
      end
    end else if (fire) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d == LOCKED) || valid_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      lock_q      <= '0;
      valid_q     <= 1'b0;
      noop_q      <= 1'b0;
      way_q       <= '0;
      set_q       <= '0;
      beat_q      <= '0;
      mask_q      <= '0;
      src_q       <= '0;
      slot_data_q <= '0;
      dat_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      valid_q     <= valid_d;
      noop_q      <= noop_d;
      way_q       <= way_d;
      set_q       <= set_d;
      beat_q      <= beat_d;
      mask_q      <= mask_d;
      src_q       <= src_d;
      slot_data_q <= slot_data_d;
      dat_q       <= dat_d;
      busy_q      <= busy_d;
    end
  end

`ifdef BS_WR_ARB_PERF_EN
  logic [NREQ*32-1:0] perf_q;

  // Counts accepted data beats per requester; noop beats are excluded and counters saturate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (accept && !sel_noop && (sel == SRCW'(i)) && (perf_q[i*32 +: 32] != '1)) begin
          perf_q[i*32 +: 32] <= perf_q[i*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign perf_beats = perf_q;
`endif

  assign bus.in_ready     = ready_vec;
  assign bus.out_valid    = valid_q;
  assign bus.out_noop     = noop_q;
  assign bus.out_way      = way_q;
  assign bus.out_set      = set_q;
  assign bus.out_beat     = beat_q;
  assign bus.out_mask     = mask_q;
  assign bus.out_src      = src_q;
  assign bus.out_dat_data = dat_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_bs_wr_arbiter.sv
// Directed self-checking bench for bs_wr_arbiter with NREQ=3 and default widths.
module tb_bs_wr_arbiter;
  import bs_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passes = 0;

  bs_wr_arbiter_if #(.NREQ(3), .WAYW(3), .SETW(10), .BEATW(2), .DATAW(128)) bus ();

`ifdef BS_WR_ARB_PERF_EN
  logic [95:0] perf_beats;
`endif

  bs_wr_arbiter #(.NREQ(3), .WAYW(3), .SETW(10), .BEATW(2), .DATAW(128)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef BS_WR_ARB_PERF_EN
    .perf_beats (perf_beats),
`endif
    .bus        (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] dat(input int i, input int b);
    return {64'h0123_4567_89AB_CDEF, 56'h0, 4'(i), 4'(b)};
  endfunction

  function automatic bs_beat_t mk(input logic n, input logic [2:0] w, input logic [9:0] s,
                                  input logic [1:0] b, input logic [1:0] m);
    bs_beat_t r;
    r.noop = n;
    r.way  = w;
    r.set  = s;
    r.beat = b;
    r.mask = m;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = '0;
    bus.in_noop   = '0;
    bus.in_way    = '0;
    bus.in_set    = '0;
    bus.in_beat   = '0;
    bus.in_mask   = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive(input int i, input logic v, input bs_beat_t bt, input logic last,
                       input logic [127:0] d);
    bus.in_valid[i]          = v;
    bus.in_noop[i]           = bt.noop;
    bus.in_way[i*3 +: 3]     = bt.way;
    bus.in_set[i*10 +: 10]   = bt.set;
    bus.in_beat[i*2 +: 2]    = bt.beat;
    bus.in_mask[i*2 +: 2]    = bt.mask;
    bus.in_last[i]           = last;
    bus.in_data[i*128 +: 128] = d;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.out_dat_data !== 128'h0) $display("FAIL reset_dat: got %h want 0", bus.out_dat_data); else passes++;
    checks++; if (bus.out_src !== 2'd0) $display("FAIL reset_src: got %0d want 0", bus.out_src); else passes++;
    checks++; if (bus.out_set !== 10'd0) $display("FAIL reset_set: got %h want 0", bus.out_set); else passes++;
    checks++; if (bus.in_ready !== 3'b000) $display("FAIL reset_in_ready: got %b want 000", bus.in_ready); else passes++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_burst();
    apply_reset();
    tick();
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, mk(1'b0, 3'd5, 10'h155, 2'(b), 2'b11), (b == 3), dat(1, b));
      settle();
      if (b == 0) begin
        checks++; if (bus.in_ready !== 3'b010) $display("FAIL single_first_ready: got %b want 010", bus.in_ready); else passes++;
      end
      tick();
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid b%0d: got %b want 1", b, bus.out_valid); else passes++;
      checks++; if (bus.out_beat !== 2'(b)) $display("FAIL single_beat b%0d: got %0d want %0d", b, bus.out_beat, b); else passes++;
      checks++; if (bus.out_src !== 2'd1) $display("FAIL single_src b%0d: got %0d want 1", b, bus.out_src); else passes++;
      checks++; if (bus.out_set !== 10'h155) $display("FAIL single_set b%0d: got %h want 155", b, bus.out_set); else passes++;
      if (b > 0) begin
        checks++; if (bus.out_dat_data !== dat(1, b - 1)) $display("FAIL single_dat b%0d: got %h want %h", b, bus.out_dat_data, dat(1, b - 1)); else passes++;
      end
    end
    drive(1, 1'b0, mk(1'b0, 3'd0, 10'h0, 2'd0, 2'd0), 1'b0, 128'h0);
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_drain_valid: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.out_dat_data !== dat(1, 3)) $display("FAIL single_last_dat: got %h want %h", bus.out_dat_data, dat(1, 3)); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy: got %b want 0", bus.busy); else passes++;
    tick();
    checks++; if (bus.out_dat_data !== dat(1, 3)) $display("FAIL single_dat_hold: got %h want %h", bus.out_dat_data, dat(1, 3)); else passes++;
    drive(0, 1'b1, mk(1'b0, 3'd1, 10'h1, 2'd0, 2'd1), 1'b1, dat(0, 0));
    drive(2, 1'b1, mk(1'b0, 3'd2, 10'h2, 2'd0, 2'd1), 1'b1, dat(2, 0));
    settle();
    checks++; if (bus.in_ready !== 3'b100) $display("FAIL single_rr_after: got %b want 100", bus.in_ready); else passes++;
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    int       cnt [3];
    int       exp_src [6];
    int       exp_beat [6];
    logic [2:0] rdy;
    exp_src  = '{0, 0, 1, 1, 2, 2};
    exp_beat = '{0, 1, 0, 1, 0, 1};
    cnt      = '{0, 0, 0};
    apply_reset();
    tick();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (cnt[i] < 2)
          drive(i, 1'b1, mk(1'b0, 3'(i), 10'(i * 7), 2'(cnt[i]), 2'b01), (cnt[i] == 1), dat(i, cnt[i]));
        else
          drive(i, 1'b0, mk(1'b0, 3'd0, 10'd0, 2'd0, 2'd0), 1'b0, 128'h0);
      end
      settle();
      checks++; if (bus.in_ready !== (3'b001 << exp_src[k])) $display("FAIL cont_ready k%0d: got %b want %b", k, bus.in_ready, 3'b001 << exp_src[k]); else passes++;
      rdy = bus.in_ready;
      tick();
      for (int i = 0; i < 3; i++) if (rdy[i]) cnt[i]++;
      checks++; if (bus.out_src !== 2'(exp_src[k])) $display("FAIL cont_src k%0d: got %0d want %0d", k, bus.out_src, exp_src[k]); else passes++;
      checks++; if (bus.out_beat !== 2'(exp_beat[k])) $display("FAIL cont_beat k%0d: got %0d want %0d", k, bus.out_beat, exp_beat[k]); else passes++;
      if (k > 0) begin
        checks++; if (bus.out_dat_data !== dat(exp_src[k-1], exp_beat[k-1])) $display("FAIL cont_dat k%0d: got %h want %h", k, bus.out_dat_data, dat(exp_src[k-1], exp_beat[k-1])); else passes++;
      end
    end
    idle_inputs();
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL cont_drain: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.out_dat_data !== dat(2, 1)) $display("FAIL cont_last_dat: got %h want %h", bus.out_dat_data, dat(2, 1)); else passes++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    tick();
    drive(0, 1'b1, mk(1'b0, 3'd3, 10'h2A, 2'd0, 2'b10), 1'b0, dat(0, 0));
    tick();
    checks++; if (bus.out_beat !== 2'd0) $display("FAIL bp_beat0: got %0d want 0", bus.out_beat); else passes++;
    drive(0, 1'b1, mk(1'b0, 3'd3, 10'h2A, 2'd1, 2'b10), 1'b0, dat(0, 1));
    tick();
    checks++; if (bus.out_beat !== 2'd1) $display("FAIL bp_beat1: got %0d want 1", bus.out_beat); else passes++;
    checks++; if (bus.out_dat_data !== dat(0, 0)) $display("FAIL bp_dat0: got %h want %h", bus.out_dat_data, dat(0, 0)); else passes++;
    drive(0, 1'b1, mk(1'b0, 3'd3, 10'h2A, 2'd2, 2'b10), 1'b0, dat(0, 2));
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (bus.in_ready !== 3'b000) $display("FAIL bp_ready c%0d: got %b want 000", c, bus.in_ready); else passes++;
      tick();
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid c%0d: got %b want 1", c, bus.out_valid); else passes++;
      checks++; if (bus.out_beat !== 2'd1) $display("FAIL bp_hold_beat c%0d: got %0d want 1", c, bus.out_beat); else passes++;
      checks++; if (bus.out_way !== 3'd3) $display("FAIL bp_hold_way c%0d: got %0d want 3", c, bus.out_way); else passes++;
      checks++; if (bus.out_dat_data !== dat(0, 0)) $display("FAIL bp_hold_dat c%0d: got %h want %h", c, bus.out_dat_data, dat(0, 0)); else passes++;
    end
    bus.out_ready = 1'b1;
    settle();
    checks++; if (bus.in_ready !== 3'b001) $display("FAIL bp_release_ready: got %b want 001", bus.in_ready); else passes++;
    tick();
    checks++; if (bus.out_beat !== 2'd2) $display("FAIL bp_beat2: got %0d want 2", bus.out_beat); else passes++;
    checks++; if (bus.out_dat_data !== dat(0, 1)) $display("FAIL bp_dat1: got %h want %h", bus.out_dat_data, dat(0, 1)); else passes++;
    drive(0, 1'b1, mk(1'b0, 3'd3, 10'h2A, 2'd3, 2'b10), 1'b1, dat(0, 3));
    tick();
    checks++; if (bus.out_beat !== 2'd3) $display("FAIL bp_beat3: got %0d want 3", bus.out_beat); else passes++;
    checks++; if (bus.out_dat_data !== dat(0, 2)) $display("FAIL bp_dat2: got %h want %h", bus.out_dat_data, dat(0, 2)); else passes++;
    idle_inputs();
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.out_dat_data !== dat(0, 3)) $display("FAIL bp_dat3: got %h want %h", bus.out_dat_data, dat(0, 3)); else passes++;
  endtask

  task automatic test_lock_stall();
    apply_reset();
    tick();
    drive(0, 1'b1, mk(1'b0, 3'd1, 10'h10, 2'd0, 2'b11), 1'b0, dat(0, 0));
    drive(2, 1'b1, mk(1'b0, 3'd2, 10'h20, 2'd3, 2'b11), 1'b1, dat(2, 3));
    settle();
    checks++; if (bus.in_ready !== 3'b001) $display("FAIL lock_first_ready: got %b want 001", bus.in_ready); else passes++;
    tick();
    checks++; if (bus.out_src !== 2'd0) $display("FAIL lock_first_src: got %0d want 0", bus.out_src); else passes++;
    drive(0, 1'b0, mk(1'b0, 3'd1, 10'h10, 2'd1, 2'b11), 1'b0, dat(0, 1));
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (bus.in_ready !== 3'b001) $display("FAIL lock_stall_ready c%0d: got %b want 001", c, bus.in_ready); else passes++;
      tick();
      checks++; if (bus.busy !== 1'b1) $display("FAIL lock_busy c%0d: got %b want 1", c, bus.busy); else passes++;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL lock_no_grant c%0d: got %b want 0", c, bus.out_valid); else passes++;
    end
    drive(0, 1'b1, mk(1'b0, 3'd1, 10'h10, 2'd1, 2'b11), 1'b1, dat(0, 1));
    tick();
    checks++; if (bus.out_src !== 2'd0) $display("FAIL lock_resume_src: got %0d want 0", bus.out_src); else passes++;
    checks++; if (bus.out_beat !== 2'd1) $display("FAIL lock_resume_beat: got %0d want 1", bus.out_beat); else passes++;
    drive(0, 1'b0, mk(1'b0, 3'd0, 10'h0, 2'd0, 2'd0), 1'b0, 128'h0);
    settle();
    checks++; if (bus.in_ready !== 3'b100) $display("FAIL lock_next_ready: got %b want 100", bus.in_ready); else passes++;
    tick();
    checks++; if (bus.out_src !== 2'd2) $display("FAIL lock_next_src: got %0d want 2", bus.out_src); else passes++;
    checks++; if (bus.out_dat_data !== dat(0, 1)) $display("FAIL lock_next_dat: got %h want %h", bus.out_dat_data, dat(0, 1)); else passes++;
    idle_inputs();
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    tick();
    drive(1, 1'b1, mk(1'b0, 3'd1, 10'h11, 2'd0, 2'b01), 1'b1, dat(1, 0));
    tick();
    checks++; if (bus.out_src !== 2'd1) $display("FAIL wrap_setup_src: got %0d want 1", bus.out_src); else passes++;
    drive(1, 1'b0, mk(1'b0, 3'd0, 10'h0, 2'd0, 2'd0), 1'b0, 128'h0);
    drive(0, 1'b1, mk(1'b0, 3'd4, 10'h3FF, 2'd0, 2'b01), 1'b1, dat(0, 0));
    drive(2, 1'b1, mk(1'b1, 3'd6, 10'h222, 2'd2, 2'b00), 1'b1, dat(2, 2));
    settle();
    checks++; if (bus.in_ready !== 3'b100) $display("FAIL wrap_ready_r2: got %b want 100", bus.in_ready); else passes++;
    tick();
    checks++; if (bus.out_src !== 2'd2) $display("FAIL wrap_src2: got %0d want 2", bus.out_src); else passes++;
    checks++; if (bus.out_noop !== 1'b1) $display("FAIL wrap_noop: got %b want 1", bus.out_noop); else passes++;
    drive(2, 1'b0, mk(1'b0, 3'd0, 10'h0, 2'd0, 2'd0), 1'b0, 128'h0);
    settle();
    checks++; if (bus.in_ready !== 3'b001) $display("FAIL wrap_ready_r0: got %b want 001", bus.in_ready); else passes++;
    tick();
    checks++; if (bus.out_src !== 2'd0) $display("FAIL wrap_src0: got %0d want 0", bus.out_src); else passes++;
    checks++; if (bus.out_set !== 10'h3FF) $display("FAIL wrap_set0: got %h want 3ff", bus.out_set); else passes++;
    checks++; if (bus.out_dat_data !== dat(2, 2)) $display("FAIL wrap_noop_dat: got %h want %h", bus.out_dat_data, dat(2, 2)); else passes++;
    drive(1, 1'b1, mk(1'b0, 3'd1, 10'h11, 2'd0, 2'b01), 1'b1, dat(1, 0));
    settle();
    checks++; if (bus.in_ready !== 3'b010) $display("FAIL wrap_rr_end: got %b want 010", bus.in_ready); else passes++;
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick();
    drive(0, 1'b1, mk(1'b0, 3'd2, 10'h0AB, 2'd0, 2'b11), 1'b0, dat(0, 0));
    tick();
    drive(0, 1'b1, mk(1'b0, 3'd2, 10'h0AB, 2'd1, 2'b11), 1'b0, dat(0, 1));
    tick();
    checks++; if (bus.out_dat_data !== dat(0, 0)) $display("FAIL areset_pre_dat: got %h want %h", bus.out_dat_data, dat(0, 0)); else passes++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.out_dat_data !== 128'h0) $display("FAIL areset_dat: got %h want 0", bus.out_dat_data); else passes++;
    checks++; if (bus.out_beat !== 2'd0) $display("FAIL areset_beat: got %0d want 0", bus.out_beat); else passes++;
    drive(0, 1'b0, mk(1'b0, 3'd0, 10'h0, 2'd0, 2'd0), 1'b0, 128'h0);
    drive(1, 1'b1, mk(1'b0, 3'd1, 10'h001, 2'd0, 2'b01), 1'b1, dat(1, 0));
    drive(2, 1'b1, mk(1'b0, 3'd7, 10'h2C2, 2'd1, 2'b01), 1'b1, dat(2, 1));
    #2;
    reset = 1'b1;
    settle();
    checks++; if (bus.in_ready !== 3'b010) $display("FAIL areset_scan_req1: got %b want 010", bus.in_ready); else passes++;
    drive(1, 1'b0, mk(1'b0, 3'd0, 10'h0, 2'd0, 2'd0), 1'b0, 128'h0);
    settle();
    checks++; if (bus.in_ready !== 3'b100) $display("FAIL areset_scan_req2: got %b want 100", bus.in_ready); else passes++;
    tick();
    checks++; if (bus.out_src !== 2'd2) $display("FAIL areset_src: got %0d want 2", bus.out_src); else passes++;
    checks++; if (bus.out_set !== 10'h2C2) $display("FAIL areset_set: got %h want 2c2", bus.out_set); else passes++;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_backpressure();
    test_lock_stall();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
